// File: rtl/ga25_sdram_arb.sv
// ga25_sdram_arb: N-channel read arbiter between GA25 graphics fetch clients
// and the shared SDRAM controller port. All logic is on the rising edge of clk,
// and reset_n is a synchronous active-low reset.
//
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   ch_addr       packed client addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_req        per-channel request strobes; a rising edge is one request
//   ch_rdy        one-cycle completion pulse for the served channel
//   ch_data       shared return data, valid while any ch_rdy bit is high
//   sdr_addr      SDRAM word address (BASE_ADDR | client address)
//   sdr_req       one-cycle request pulse to the controller
//   sdr_64bit     high for a 64-bit burst
//   sdr_data      SDRAM read data
//   sdr_rdy       one-cycle data-valid from the controller
//   timeout_err   sticky watchdog error
//
// Optional feature: define GA25_SDRAM_ARB_TIMEOUT_EN to enable the WAIT
// watchdog (TIMEOUT cycles). Without it, timeout_err is tied low.
module ga25_sdram_arb #(
  parameter int unsigned            NUM_CH     = 4,
  parameter int unsigned            ADDR_W     = 22,
  parameter int unsigned            SDR_ADDR_W = 25,
  parameter logic [SDR_ADDR_W-1:0]  BASE_ADDR  = '0,
  parameter logic [7:0]             WIDE_MASK  = 8'b0000_1000,
  parameter bit                     RR_MODE    = 1'b0,
  parameter int unsigned            TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_req,
  output logic [NUM_CH-1:0]        ch_rdy,
  output logic [63:0]              ch_data,
  output logic [SDR_ADDR_W-1:0]    sdr_addr,
  output logic                     sdr_req,
  output logic                     sdr_64bit,
  input  logic [63:0]              sdr_data,
  input  logic                     sdr_rdy,
  output logic                     timeout_err
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                              state_q, state_d;
  logic [NUM_CH-1:0]                   req_q;
  logic [NUM_CH-1:0]                   pending_q, pending_d;
  logic [NUM_CH-1:0][SDR_ADDR_W-1:0]   addr_q, addr_d;
  logic [CH_W-1:0]                     grant_q, grant_d;
  logic [CH_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]                   ch_rdy_d;
  logic [63:0]                         ch_data_d;
  logic [SDR_ADDR_W-1:0]               sdr_addr_d;
  logic                                sdr_req_d;
  logic                                sdr_64bit_d;
  logic [NUM_CH-1:0]                   req_edge;
  logic                                sel_valid;
  logic [CH_W-1:0]                     sel_idx;
  logic [CH_W-1:0]                     rr_idx;

`ifdef GA25_SDRAM_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_edge = ch_req & ~req_q;

  // Channel selection. Loops run from lowest to highest priority so the
  // last match wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    rr_idx    = '0;
    if (RR_MODE) begin
      for (int unsigned k = NUM_CH; k >= 1; k--) begin
        rr_idx = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
        if (pending_q[rr_idx]) begin
          sel_valid = 1'b1;
          sel_idx   = rr_idx;
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel_valid = 1'b1;
          sel_idx   = CH_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    addr_d      = addr_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    ch_rdy_d    = '0;
    ch_data_d   = ch_data;
    sdr_addr_d  = sdr_addr;
    sdr_req_d   = 1'b0;
    sdr_64bit_d = sdr_64bit;
`ifdef GA25_SDRAM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          sdr_addr_d         = addr_q[sel_idx];
          sdr_64bit_d        = WIDE_MASK[sel_idx];
          sdr_req_d          = 1'b1;
          pending_d[sel_idx] = 1'b0;
          grant_d            = sel_idx;
          rr_ptr_d           = sel_idx;
          state_d            = StWait;
`ifdef GA25_SDRAM_ARB_TIMEOUT_EN
          cnt_d              = '0;
`endif
        end
      end
      StWait: begin
        // sdr_rdy is ignored during the cycle the request pulse is out.
        if (sdr_rdy && !sdr_req) begin
          ch_rdy_d[grant_q] = 1'b1;
          ch_data_d         = WIDE_MASK[grant_q] ? sdr_data : {32'h0, sdr_data[31:0]};
          state_d           = StIdle;
        end
`ifdef GA25_SDRAM_ARB_TIMEOUT_EN
        else if (cnt_q + 32'd1 == TIMEOUT) begin
          ch_rdy_d[grant_q] = 1'b1;
          ch_data_d         = '0;
          timeout_d         = 1'b1;
          state_d           = StIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // New edges land after the grant clear, so a same-cycle re-request of the
    // granted channel stays pending with its fresh address.
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_edge[i] && !pending_d[i]) begin
        addr_d[i] = BASE_ADDR | SDR_ADDR_W'(ch_addr[i*ADDR_W +: ADDR_W]);
      end
    end
    pending_d = pending_d | req_edge;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      req_q     <= '0;
      pending_q <= '0;
      addr_q    <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= CH_W'(NUM_CH - 1);
      ch_rdy    <= '0;
      ch_data   <= '0;
      sdr_addr  <= '0;
      sdr_req   <= 1'b0;
      sdr_64bit <= 1'b0;
`ifdef GA25_SDRAM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= ch_req;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      ch_rdy    <= ch_rdy_d;
      ch_data   <= ch_data_d;
      sdr_addr  <= sdr_addr_d;
      sdr_req   <= sdr_req_d;
      sdr_64bit <= sdr_64bit_d;
`ifdef GA25_SDRAM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: doc/ga25_sdram_arb.md
Name: ga25_sdram_arb

Overview:
- Parametrised N-channel read arbiter between GA25 graphics fetch clients and the shared SDRAM controller port.
- Generalises the fixed three-channel GFX arbiter:
  - configurable channel count and address width;
  - per-channel 32/64-bit fetch width;
  - fixed-priority or round-robin selection;
  - single clock domain, with the SDRAM handshake synchronous to clk.
- Sits between the tile/sprite fetch units and the board SDRAM controller.

Parameters:
- NUM_CH, 4: number of client channels, 2..8.
- ADDR_W, 22: client address width.
- SDR_ADDR_W, 25: SDRAM address width, >= ADDR_W.
- BASE_ADDR, 25'h0: region base, ORed with the zero-extended client address.
- WIDE_MASK, 4'b1000: bit i set means channel i is a 64-bit fetch; clear means 32-bit.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 255: watchdog limit in cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ch_addr  in  NUM_CH*ADDR_W  packed client addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_req  in  NUM_CH  request strobes; a 0->1 transition is one request.
- ch_rdy  out  NUM_CH  one-cycle completion pulse per channel.
- ch_data  out  64  shared return data; valid while any ch_rdy is high.
- sdr_addr  out  SDR_ADDR_W  SDRAM word address.
- sdr_req  out  1  one-cycle request pulse.
- sdr_64bit  out  1  high means a 64-bit burst for the current request.
- sdr_data  in  64  SDRAM read data.
- sdr_rdy  in  1  one-cycle data-valid from the controller.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (reset_n low at an edge):
  - State goes to IDLE.
  - pending, req_d, ch_rdy, sdr_req, sdr_64bit and timeout_err go to 0; sdr_addr, ch_data go to 0.
  - Round-robin pointer goes to NUM_CH-1, so channel 0 is served first.
  - An in-flight transaction is abandoned; a later sdr_rdy arriving in IDLE is ignored.
- Capture:
  - req_d[i] registers ch_req[i].
  - ch_req[i] & ~req_d[i] sets pending[i] and latches addr_q[i] = BASE_ADDR | zero-extended ch_addr slice.
  - A new edge while pending[i] is already set is dropped; the original address is kept.
- States: IDLE and WAIT.
- IDLE, with any pending bit set:
  - Select channel g.
    - Fixed mode: lowest-index pending channel.
    - RR mode: first pending index after the pointer, wrapping modulo NUM_CH.
  - Registered outputs: sdr_addr = addr_q[g], sdr_64bit = WIDE_MASK[g], sdr_req = 1 for exactly one cycle.
  - Clear pending[g], store g, set RR pointer = g, go to WAIT.
  - If the same channel's new edge arrives on the grant cycle, the set wins and the new request stays pending.
- WAIT:
  - sdr_req = 0.
  - On sdr_rdy:
    - ch_data = sdr_data for wide channels; {32'h0, sdr_data[31:0]} for narrow channels.
    - ch_rdy[g] = 1 for one cycle; return to IDLE.
  - sdr_rdy is not sampled on the cycle sdr_req is asserted.
- Latency:
  - ch_req edge sampled at edge N -> sdr_req high after edge N+1 (idle arbiter).
  - sdr_rdy sampled at edge M -> ch_rdy high after M.
  - Next sdr_req no earlier than after M+1.
- Ordering:
  - At most one ch_rdy bit is high per cycle.
  - Exactly one outstanding SDRAM request at a time.
- sdr_addr, sdr_64bit and ch_data hold their values between transactions.

Optional Feature:
- Macro: GA25_SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without sdr_rdy: ch_rdy[g] pulses with ch_data = 64'h0, timeout_err sets (sticky until reset), state returns to IDLE.
  - An sdr_rdy arriving later is ignored.
- Not defined:
  - No counter; WAIT persists until sdr_rdy.
  - timeout_err is tied to 0.

Test Plan:
- Reset then single request: ch_req[1] edge with ch_addr slice 22'h012340, BASE_ADDR 25'h1000000.
  - sdr_addr = 25'h1012340, sdr_64bit = 0, one-cycle sdr_req.
  - sdr_rdy with sdr_data 64'hDEADBEEF_CAFEF00D -> ch_rdy[1] pulse, ch_data = 64'h00000000_CAFEF00D.
- Wide channel: request on ch3.
  - sdr_64bit = 1.
  - ch_data = full 64'h0123456789ABCDEF.
- Fixed priority: RR_MODE = 0, edges on ch0..ch3 in the same cycle.
  - Grants go 0, 1, 2, 3.
  - Re-request ch0 during the ch1 transaction -> ch0 is granted before ch2.
- Round-robin: RR_MODE = 1, all four channels requested continuously.
  - Grant order is 0, 1, 2, 3, 0, 1.
  - No channel is granted twice before the others.
- Reset mid-WAIT: assert reset_n = 0 while ch2 is outstanding.
  - All outputs go to 0.
  - A subsequent sdr_rdy produces no ch_rdy.
  - A new ch0 request then issues normally.
- Timeout, with the macro defined and TIMEOUT = 16: never assert sdr_rdy.
  - At WAIT cycle 16: ch_rdy[g] pulses, ch_data = 0, timeout_err = 1 and stays set.
  - Next pending request is served.
